mem_io_responder: RTL



---
 rtl/mem_io_responder_if.sv | 11 +
 rtl/mem_io_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory port between the CPU memory controller (master) and mem_io_responder (slave).
interface mem_io_responder_if;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;

  modport master (output rdy_in, output cpu_a, output cpu_wr, output cpu_wdata, input cpu_rdata);
  modport slave  (input rdy_in, input cpu_a, input cpu_wr, input cpu_wdata, output cpu_rdata);
endinterface

// File: rtl/mem_io_responder.sv
// CPU memory-port responder: 128KB byte RAM, UART tx/rx FIFOs, cycle counter, program-stop flag.
// Optional rx FIFO is built only when the macro MEMIO_RX_EN is defined.
module mem_io_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH_W = 3,
  parameter int TX_MARGIN  = 2,
  parameter int RX_DEPTH_W = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_io_responder_if.slave   bus,
  output logic                io_buffer_full,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                prog_stop
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_W;

  logic [7:0]            r_ram [2**RAM_ADDR_W];
  logic [7:0]            r_ram_q;
  logic                  r_src_ram;
  logic [7:0]            r_io_q;
  logic [31:0]           r_cycle;
  logic [31:0]           r_snap;
  logic                  r_prog_stop;
  logic [7:0]            r_tx_mem [TX_DEPTH];
  logic [TX_DEPTH_W-1:0] r_tx_wr_ptr;
  logic [TX_DEPTH_W-1:0] r_tx_rd_ptr;
  logic [TX_DEPTH_W:0]   r_tx_count;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_is_ram;
  logic                  w_is_io;
  logic [2:0]            w_sub;
  logic [RAM_ADDR_W-1:0] w_ram_addr;
  logic [7:0]            w_io_rdata;
  logic [7:0]            w_rx_head;
  logic                  w_tx_push;
  logic [7:0]            w_tx_push_data;
  logic                  w_tx_pop;
  logic                  w_addr_unused;

  assign w_rd_acc      = bus.rdy_in && !bus.cpu_wr;
  assign w_wr_acc      = bus.rdy_in && bus.cpu_wr;
  assign w_is_ram      = !bus.cpu_a[17];
  assign w_is_io       = (bus.cpu_a[17:16] == 2'b11);
  assign w_sub         = bus.cpu_a[2:0];
  assign w_ram_addr    = bus.cpu_a[RAM_ADDR_W-1:0];
  assign w_addr_unused = ^bus.cpu_a[31:18];

  // 0x30004 writes push a 0x00 marker so the host sees the stop in the tx stream.
  assign w_tx_push_data = (w_sub == 3'd4) ? 8'h00 : bus.cpu_wdata;
  assign w_tx_push = w_wr_acc && w_is_io
                     && ((w_sub == 3'd0 && bus.cpu_wdata != 8'h00) || w_sub == 3'd4)
                     && (r_tx_count != (TX_DEPTH_W+1)'(TX_DEPTH));
  assign w_tx_pop  = tx_valid && tx_ready;

  assign tx_valid       = (r_tx_count != '0);
  assign tx_data        = tx_valid ? r_tx_mem[r_tx_rd_ptr] : 8'h00;
  assign io_buffer_full = (r_tx_count >= (TX_DEPTH_W+1)'(TX_DEPTH - TX_MARGIN));
  assign prog_stop      = r_prog_stop;
  assign bus.cpu_rdata  = r_src_ram ? r_ram_q : r_io_q;

`ifdef MEMIO_RX_EN
  localparam int RX_DEPTH = 1 << RX_DEPTH_W;

  logic [7:0]            r_rx_mem [RX_DEPTH];
  logic [RX_DEPTH_W-1:0] r_rx_wr_ptr;
  logic [RX_DEPTH_W-1:0] r_rx_rd_ptr;
  logic [RX_DEPTH_W:0]   r_rx_count;
  logic                  w_rx_push;
  logic                  w_rx_pop;

  assign w_rx_push = rx_valid && (r_rx_count != (RX_DEPTH_W+1)'(RX_DEPTH));
  assign w_rx_pop  = w_rd_acc && w_is_io && (w_sub == 3'd0) && (r_rx_count != '0);
  assign w_rx_head = (r_rx_count != '0) ? r_rx_mem[r_rx_rd_ptr] : 8'h00;

  always_ff @(posedge clk_in) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
    end
  end
`else
  logic w_rx_unused;
  assign w_rx_unused = (^{rx_data, rx_valid}) ^ (RX_DEPTH_W != 0);
  assign w_rx_head   = 8'h00;
`endif

  always_comb begin
    w_io_rdata = 8'h00;
    case (w_sub)
      3'd0:    w_io_rdata = w_rx_head;
      3'd4:    w_io_rdata = r_cycle[7:0];
      3'd5:    w_io_rdata = r_snap[15:8];
      3'd6:    w_io_rdata = r_snap[23:16];
      3'd7:    w_io_rdata = r_snap[31:24];
      default: w_io_rdata = 8'h00;
    endcase
  end

  // RAM port kept free of reset so it maps onto block RAM; r_src_ram selects it on the output.
  always_ff @(posedge clk_in) begin
    if (w_wr_acc && w_is_ram) r_ram[w_ram_addr] <= bus.cpu_wdata;
    if (w_rd_acc && w_is_ram) r_ram_q <= r_ram[w_ram_addr];
  end

  always_ff @(posedge clk_in) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= w_tx_push_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_src_ram   <= 1'b0;
      r_io_q      <= 8'h00;
      r_cycle     <= '0;
      r_snap      <= '0;
      r_prog_stop <= 1'b0;
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_rd_acc) begin
        r_src_ram <= w_is_ram;
        r_io_q    <= w_is_io ? w_io_rdata : 8'h00;
        if (w_is_io && w_sub == 3'd4) r_snap <= r_cycle;
      end
      if (w_wr_acc && w_is_io && w_sub == 3'd4) r_prog_stop <= 1'b1;
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - 1'b1;
    end
  end
endmodule
